// File: rtl/miner_nonce_scheduler.sv
// miner_nonce_scheduler
// Nonce-search controller: spreads a job's nonce range across NUM_LANES external
// SHA-256d lanes, retires digests through a round-robin arbiter, and reports
// the first digest <= target or range exhaustion. Also drives the status LED.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a job; job_ready high
// ST_RUN     | dispatching nonces to free lanes and retiring digests
// ST_FOUND   | hit reported on found_valid; lanes still retired and dropped
// ST_DRAIN   | hit consumed; retiring and dropping remaining in-flight lanes
// ST_EXHAUST | range finished with no hit; done pulses for this one cycle
//
// lane_start, lane_digest_ack and the nonce of the lane being started are
// decoded combinationally so a lane sees start and nonce together, and so
// a retire and its compare happen in the same cycle. Everything else is
// registered.

module miner_nonce_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int NONCE_W   = 32,
  parameter int LED_DIV   = 24
) (
  input  logic                         clock,
  input  logic                         reset,   // active-low, asynchronous
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [NONCE_W-1:0]           job_nonce_start,
  input  logic [NONCE_W-1:0]           job_nonce_end,
  input  logic [255:0]                 job_target,
  input  logic [NUM_LANES-1:0]         lane_ready,
  output logic [NUM_LANES-1:0]         lane_start,
  output logic [NUM_LANES*NONCE_W-1:0] lane_nonce,
  input  logic [NUM_LANES-1:0]         lane_digest_valid,
  input  logic [NUM_LANES*256-1:0]     lane_digest,
  output logic [NUM_LANES-1:0]         lane_digest_ack,
  output logic                         found_valid,
  output logic [NONCE_W-1:0]           found_nonce,
  input  logic                         found_ack,
  output logic                         done,
  output logic                         busy,
  output logic                         led
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FOUND   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_EXHAUST = 3'd4
  } state_t;

  state_t               state;
  logic [NONCE_W-1:0]   nonce_end;
  logic [255:0]         target_q;
  logic [NONCE_W-1:0]   next_nonce;
  logic                 issued_all;
  logic [NUM_LANES-1:0] in_flight;
  logic [NONCE_W-1:0]   nonce_q [NUM_LANES];
  logic [PTR_W-1:0]     rr_ptr;
  logic [LED_DIV-1:0]   led_cnt;

  logic [NUM_LANES-1:0] retire_cand;
  logic [NUM_LANES-1:0] ack_vec;
  logic [NUM_LANES-1:0] start_vec;
  logic [NUM_LANES-1:0] in_flight_nxt;
  logic                 ret_any;
  logic [PTR_W-1:0]     ret_idx;
  logic [PTR_W-1:0]     arb_sel;
  logic                 disp_any;
  logic [255:0]         win_digest;
  logic [NONCE_W-1:0]   win_nonce;
  logic                 hit_now;

  assign job_ready       = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign lane_start      = start_vec;
  assign lane_digest_ack = ack_vec;

  // Only lanes we actually launched may be retired; stray digest_valid is ignored.
  assign retire_cand   = lane_digest_valid & in_flight;
  assign in_flight_nxt = (in_flight & ~ack_vec) | start_vec;
  assign win_digest    = lane_digest[int'(ret_idx)*256 +: 256];
  assign win_nonce     = nonce_q[ret_idx];
  assign hit_now       = (state == ST_RUN) && ret_any && (win_digest <= target_q);

  // Round-robin retire arbiter: first candidate at or after rr_ptr.
  always_comb begin
    ret_any = 1'b0;
    ret_idx = '0;
    arb_sel = '0;
    ack_vec = '0;
    if (state == ST_RUN || state == ST_FOUND || state == ST_DRAIN) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        arb_sel = PTR_W'((int'(rr_ptr) + k) % NUM_LANES);
        if (!ret_any && retire_cand[arb_sel]) begin
          ret_any = 1'b1;
          ret_idx = arb_sel;
        end
      end
    end
    if (ret_any) ack_vec[ret_idx] = 1'b1;
  end

  // Dispatch to the lowest-index idle lane; a hit this cycle already stops dispatch.
  always_comb begin
    start_vec = '0;
    disp_any  = 1'b0;
    if (state == ST_RUN && !issued_all && !hit_now) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!disp_any && lane_ready[i] && !in_flight[i]) begin
          disp_any     = 1'b1;
          start_vec[i] = 1'b1;
        end
      end
    end
  end

  // Lane nonce bus: the lane being started sees next_nonce in its start cycle.
  always_comb begin
    lane_nonce = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_nonce[i*NONCE_W +: NONCE_W] = start_vec[i] ? next_nonce : nonce_q[i];
    end
  end

  // Per-lane bookkeeping: in-flight flags, issued nonces, arbiter pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_LANES; i++) nonce_q[i] <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      if (ret_any) begin
        rr_ptr <= (ret_idx == PTR_W'(NUM_LANES - 1)) ? '0 : ret_idx + 1'b1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (start_vec[i]) nonce_q[i] <= next_nonce;
      end
    end
  end

  // Main FSM with job registers, found/done reporting and LED divider.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      nonce_end   <= '0;
      target_q    <= '0;
      next_nonce  <= '0;
      issued_all  <= 1'b0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      done        <= 1'b0;
      led         <= 1'b0;
      led_cnt     <= '0;
    end else begin
      done <= 1'b0;
      // Counter stops at end rather than wrapping, so end = all-ones is safe.
      if (disp_any) begin
        if (next_nonce == nonce_end) issued_all <= 1'b1;
        else                         next_nonce <= next_nonce + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          led <= 1'b0;
          if (job_valid) begin
            nonce_end  <= job_nonce_end;
            target_q   <= job_target;
            next_nonce <= job_nonce_start;
            issued_all <= 1'b0;
            led_cnt    <= '1;
            if (job_nonce_start > job_nonce_end) begin
              state <= ST_EXHAUST;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (hit_now) begin
            found_valid <= 1'b1;
            found_nonce <= win_nonce;
            led         <= 1'b1;
            state       <= ST_FOUND;
          end else if (issued_all && in_flight_nxt == '0) begin
            done  <= 1'b1;
            led   <= 1'b0;
            state <= ST_EXHAUST;
          end else if (led_cnt == '0) begin
            led     <= ~led;
            led_cnt <= '1;
          end else begin
            led_cnt <= led_cnt - 1'b1;
          end
        end
        ST_FOUND: begin
          led <= 1'b1;
          if (found_ack) begin
            found_valid <= 1'b0;
            if (in_flight_nxt == '0) begin
              led   <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (in_flight_nxt == '0) begin
            led   <= 1'b0;
            state <= ST_IDLE;
          end else if (led_cnt == '0) begin
            led     <= ~led;
            led_cnt <= '1;
          end else begin
            led_cnt <= led_cnt - 1'b1;
          end
        end
        ST_EXHAUST: begin
          led   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// tb_miner_nonce_scheduler
// Directed bench for miner_nonce_scheduler with 4 lanes, 32-bit nonces and a
// short LED divider; lanes are modelled by driving ready/valid/digest directly.

module tb_miner_nonce_scheduler;

  localparam int NL = 4;
  localparam int NW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [NW-1:0]   job_nonce_start = '0;
  logic [NW-1:0]   job_nonce_end = '0;
  logic [255:0]    job_target = '0;
  logic [NL-1:0]   lane_ready = '0;
  logic [NL-1:0]   lane_start;
  logic [NL*NW-1:0] lane_nonce;
  logic [NL-1:0]   lane_digest_valid = '0;
  logic [NL*256-1:0] lane_digest = '0;
  logic [NL-1:0]   lane_digest_ack;
  logic            found_valid;
  logic [NW-1:0]   found_nonce;
  logic            found_ack = 1'b0;
  logic            done;
  logic            busy;
  logic            led;

  int n_checks = 0;
  int n_pass   = 0;

  miner_nonce_scheduler #(.NUM_LANES(NL), .NONCE_W(NW), .LED_DIV(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_nonce_start   (job_nonce_start),
    .job_nonce_end     (job_nonce_end),
    .job_target        (job_target),
    .lane_ready        (lane_ready),
    .lane_start        (lane_start),
    .lane_nonce        (lane_nonce),
    .lane_digest_valid (lane_digest_valid),
    .lane_digest       (lane_digest),
    .lane_digest_ack   (lane_digest_ack),
    .found_valid       (found_valid),
    .found_nonce       (found_nonce),
    .found_ack         (found_ack),
    .done              (done),
    .busy              (busy),
    .led               (led)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] nonce_of(input int l);
    return 64'(lane_nonce[l*NW +: NW]);
  endfunction

  task automatic set_digest(input int l, input logic [255:0] d);
    lane_digest[l*256 +: 256] = d;
  endtask

  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [255:0] t);
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = t;
    job_valid       = 1'b1;
    step();
    job_valid       = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1 reset = 1'b0;
    #1;
    check_eq("rst_job_ready", 64'(job_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_led", 64'(led), 64'd0);
    check_eq("rst_found_valid", 64'(found_valid), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_lane_start", 64'(lane_start), 64'd0);
    check_eq("rst_nonce_lo", lane_nonce[63:0], 64'd0);
    check_eq("rst_nonce_hi", lane_nonce[127:64], 64'd0);
    step();
    reset = 1'b1;
    lane_ready = 4'hF;
    for (int l = 0; l < NL; l++) set_digest(l, 256'h1);

    // Exhaust run: range 0..7, target 0, every digest misses
    start_job(32'd0, 32'd7, 256'h0);
    check_eq("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_start", 64'(lane_start), 64'(1 << i));
      check_eq("t1_nonce", nonce_of(i), 64'(i));
      step();
    end
    for (int c = 4; c <= 8; c++) begin
      check_eq("t1_idle_start", 64'(lane_start), 64'd0);
      if (c == 7) check_eq("t1_led_pre", 64'(led), 64'd0);
      if (c == 8) check_eq("t1_led_tog", 64'(led), 64'd1);
      if (c < 8) step();
    end
    for (int r = 0; r < 8; r++) begin
      lane_digest_valid = 4'(1 << (r % 4));
      #1;
      check_eq("t1_ack", 64'(lane_digest_ack), 64'(1 << (r % 4)));
      step();
      lane_digest_valid = '0;
      #1;
      check_eq("t1_ack_clr", 64'(lane_digest_ack), 64'd0);
      if (r < 4) begin
        check_eq("t1_redispatch", 64'(lane_start), 64'(1 << r));
        check_eq("t1_renonce", nonce_of(r), 64'(4 + r));
      end else begin
        check_eq("t1_no_dispatch", 64'(lane_start), 64'd0);
      end
      check_eq("t1_done", 64'(done), (r == 7) ? 64'd1 : 64'd0);
      check_eq("t1_found", 64'(found_valid), 64'd0);
      if (r == 7) check_eq("t1_led_exh", 64'(led), 64'd0);
      step();
    end
    check_eq("t1_done_clr", 64'(done), 64'd0);
    check_eq("t1_idle", 64'(job_ready), 64'd1);

    // Arbitration with pointer 0, then reset mid-run
    start_job(32'd0, 32'd7, 256'h0);
    for (int i = 0; i < 4; i++) step();
    lane_digest_valid = 4'b1001;
    #1;
    check_eq("t3_ack0", 64'(lane_digest_ack), 64'b0001);
    step();
    lane_digest_valid = 4'b1000;
    #1;
    check_eq("t3_ack3", 64'(lane_digest_ack), 64'b1000);
    check_eq("t3_disp0", 64'(lane_start), 64'b0001);
    check_eq("t3_disp0_nonce", nonce_of(0), 64'd4);
    step();
    lane_digest_valid = 4'b0000;
    #1;
    check_eq("t3_no_reack", 64'(lane_digest_ack), 64'd0);
    check_eq("t3_disp3", 64'(lane_start), 64'b1000);
    check_eq("t3_disp3_nonce", nonce_of(3), 64'd5);
    lane_digest_valid = 4'b0010;
    #1;
    reset = 1'b0;
    #1;
    check_eq("t6_start", 64'(lane_start), 64'd0);
    check_eq("t6_ack", 64'(lane_digest_ack), 64'd0);
    check_eq("t6_nonce_lo", lane_nonce[63:0], 64'd0);
    check_eq("t6_nonce_hi", lane_nonce[127:64], 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_ready", 64'(job_ready), 64'd1);
    check_eq("t6_done", 64'(done), 64'd0);
    check_eq("t6_led", 64'(led), 64'd0);
    lane_digest_valid = '0;
    step();
    reset = 1'b1;

    // Hit on lane 2 with target all-ones, then drain
    start_job(32'd0, 32'd7, {256{1'b1}});
    for (int i = 0; i < 4; i++) step();
    set_digest(2, 256'h1234);
    lane_digest_valid = 4'b0100;
    #1;
    check_eq("t2_ack2", 64'(lane_digest_ack), 64'b0100);
    step();
    lane_digest_valid = '0;
    #1;
    check_eq("t2_found_valid", 64'(found_valid), 64'd1);
    check_eq("t2_found_nonce", 64'(found_nonce), 64'd2);
    check_eq("t2_led", 64'(led), 64'd1);
    check_eq("t2_no_dispatch", 64'(lane_start), 64'd0);
    found_ack = 1'b1;
    step();
    found_ack = 1'b0;
    #1;
    check_eq("t2_found_clr", 64'(found_valid), 64'd0);
    check_eq("t2_drain_busy", 64'(job_ready), 64'd0);
    lane_digest_valid = 4'b1111;
    #1;
    check_eq("t2_drain_ack3", 64'(lane_digest_ack), 64'b1000);
    step();
    lane_digest_valid = 4'b0111;
    #1;
    check_eq("t2_drain_ack0", 64'(lane_digest_ack), 64'b0001);
    step();
    lane_digest_valid = 4'b0110;
    #1;
    check_eq("t2_drain_ack1", 64'(lane_digest_ack), 64'b0010);
    step();
    lane_digest_valid = 4'b0100;
    #1;
    check_eq("t2_stray_ack", 64'(lane_digest_ack), 64'd0);
    check_eq("t2_idle", 64'(job_ready), 64'd1);
    check_eq("t2_led_idle", 64'(led), 64'd0);
    lane_digest_valid = '0;
    set_digest(2, 256'h1);

    // Single nonce at the top of the range, no wrap
    start_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 256'h0);
    check_eq("t4_start", 64'(lane_start), 64'b0001);
    check_eq("t4_nonce", nonce_of(0), 64'hFFFF_FFFF);
    step();
    check_eq("t4_no_wrap_a", 64'(lane_start), 64'd0);
    step();
    check_eq("t4_no_wrap_b", 64'(lane_start), 64'd0);
    lane_digest_valid = 4'b0001;
    #1;
    check_eq("t4_ack", 64'(lane_digest_ack), 64'b0001);
    step();
    lane_digest_valid = '0;
    #1;
    check_eq("t4_done", 64'(done), 64'd1);
    check_eq("t4_found", 64'(found_valid), 64'd0);
    step();
    check_eq("t4_done_clr", 64'(done), 64'd0);

    // Empty range: start > end
    start_job(32'd5, 32'd3, 256'h0);
    check_eq("t5_done", 64'(done), 64'd1);
    check_eq("t5_no_start", 64'(lane_start), 64'd0);
    check_eq("t5_busy", 64'(busy), 64'd1);
    step();
    check_eq("t5_done_clr", 64'(done), 64'd0);
    check_eq("t5_idle", 64'(job_ready), 64'd1);
    check_eq("t5_no_start2", 64'(lane_start), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
